// File: rtl/gf16_horner_eval.sv
// Streaming GF(2^4) Horner polynomial evaluator (field poly x^4+x+1), one coefficient per cycle.
// Optional root-detect output res_zero is enabled by defining GF_HORNER_ZERO_FLAG_EN.
module gf16_horner_eval #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       x_in,
  input  logic             coef_valid,
  output logic             coef_ready,
  input  logic [3:0]       coef_data,
  input  logic             coef_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_data,
  output logic [CNT_W-1:0] res_count,
`ifdef GF_HORNER_ZERO_FLAG_EN
  output logic             res_zero,
`endif
  output logic             busy
);

  localparam int unsigned SYM_W  = 4;
  localparam int unsigned PROD_W = 2 * SYM_W - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q;
  logic [SYM_W-1:0]   acc_q;
  logic [SYM_W-1:0]   x_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               coef_ready_q;
  logic               res_valid_q;
  logic [SYM_W-1:0]   res_data_q;
  logic [CNT_W-1:0]   res_count_q;
  logic               busy_q;
  logic               res_zero_q;

  logic               accept_c;
  logic [SYM_W-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_d;

  // Mastrovito-style multiply: carry-less product folded with x^4=x+1, x^5=x^2+x, x^6=x^3+x^2
  function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                              input logic [SYM_W-1:0] b);
    logic [PROD_W-1:0] p;
    logic [SYM_W-1:0]  r;
    p = '0;
    for (int i = 0; i < int'(SYM_W); i++) begin
      if (b[i]) p = p ^ (PROD_W'(a) << i);
    end
    r[0] = p[0] ^ p[4];
    r[1] = p[1] ^ p[4] ^ p[5];
    r[2] = p[2] ^ p[5] ^ p[6];
    r[3] = p[3] ^ p[6];
    return r;
  endfunction

  // coef_ready_q is only ever set while in ACCUM
  assign accept_c = coef_valid & coef_ready_q;
  assign acc_d    = gf_mul(acc_q, x_q) ^ coef_data;
  assign cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      x_q          <= '0;
      cnt_q        <= '0;
      coef_ready_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_count_q  <= '0;
      busy_q       <= 1'b0;
      res_zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q          <= x_in;
            acc_q        <= '0;
            cnt_q        <= '0;
            coef_ready_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept_c) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (coef_last) begin
              coef_ready_q <= 1'b0;
              res_valid_q  <= 1'b1;
              res_data_q   <= acc_d;
              res_count_q  <= cnt_d;
              res_zero_q   <= (acc_d == '0);
              state_q      <= DONE;
            end
          end
        end
        DONE: begin
          // result held until the downstream handshake; start is not looked at here
          if (res_ready) begin
            res_valid_q <= 1'b0;
            res_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q      <= IDLE;
          coef_ready_q <= 1'b0;
          res_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign coef_ready = coef_ready_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_count  = res_count_q;
  assign busy       = busy_q;

`ifdef GF_HORNER_ZERO_FLAG_EN
  assign res_zero = res_zero_q;
`else
  logic unused_zero_c;
  assign unused_zero_c = res_zero_q;
`endif

endmodule

// File: doc/gf16_horner_eval.md
Name: gf16_horner_eval

Overview:
- Sequential GF(2^4) polynomial evaluator; field polynomial x^4 + x + 1.
- Consumes a stream of 4-bit coefficients, highest degree first, and evaluates the polynomial at a point x using Horner's rule: acc = acc*x ^ coef.
- Performs one GF(2^4) multiply per accepted coefficient, using the team's combinational 4-bit Mastrovito multiplier.
- Sits between the symbol source and the downstream decoder logic, for example as a Reed-Solomon syndrome/root-check stage.

Parameters:
- CNT_W, 8, width of the accepted-term counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin an evaluation; honoured only in IDLE
- x_in  input  4  evaluation point; sampled when start is honoured
- coef_valid  input  1  coefficient available
- coef_ready  output  1  block accepts a coefficient
- coef_data  input  4  coefficient, highest degree first
- coef_last  input  1  marks the final coefficient (constant term)
- res_valid  output  1  result available
- res_ready  input  1  downstream accepts the result
- res_data  output  4  P(x) in GF(2^4)
- res_count  output  CNT_W  number of coefficients accepted
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: state=IDLE, acc=0, x_reg=0, count=0, res_valid=0, res_data=0, res_count=0, coef_ready=0, busy=0. Reset wins over every other input in the same cycle.
- IDLE:
  - coef_ready=0.
  - On start=1: x_reg<=x_in, acc<=0, count<=0, go to ACCUM.
  - coef_valid is ignored in IDLE.
- ACCUM:
  - coef_ready=1.
  - A coefficient is accepted on a cycle with coef_valid & coef_ready.
  - On accept: acc <= gfmul(acc, x_reg) ^ coef_data; count <= count+1. count saturates at all-ones and never wraps.
  - The first accept yields acc=coef_data, because acc starts at 0.
  - Accept with coef_last=1: go to DONE. res_data/res_count are loaded with the new acc/count, and res_valid=1 from the next cycle. Latency is 1 cycle from the last accept to res_valid.
  - Cycles without coef_valid stall; state and acc are held.
- DONE:
  - coef_ready=0; res_valid=1.
  - res_data and res_count are held stable until res_ready=1.
  - On res_valid & res_ready: res_valid<=0, go to IDLE.
  - A start in the same cycle as the handshake is ignored.
- gfmul is the carry-less 4x4 product reduced modulo x^4+x+1. Bit reduction rules: x^4=x+1, x^5=x^2+x, x^6=x^3+x^2.
- start while busy=1 is ignored, with no effect on acc, x_reg or count.
- x_in=0: the result equals the last coefficient. x_in=1: the result is the XOR of all coefficients.
- A single-coefficient stream (coef_last on the first accept) gives res_data=coef_data and res_count=1.
- Reset mid-ACCUM or mid-DONE: return to IDLE with all outputs at reset values; the pending result is discarded.
- Throughput: one coefficient per cycle. Minimum evaluation is start + N + 1 cycles to res_valid, plus the handshake cycle.

Optional Feature:
- Macro GF_HORNER_ZERO_FLAG_EN.
- Defined:
  - Adds output res_zero (1 bit), reset 0.
  - res_zero is loaded with (acc_next==0) together with res_data, is valid while res_valid=1, and is cleared when the block returns to IDLE.
  - Used as a root-detect flag.
- Undefined: port res_zero does not exist; all other behaviour is identical.

Test Plan:
- start with x_in=2, coefs [1,0,1] (last on the 3rd), res_ready=1 -> res_data=5, res_count=3, res_valid exactly one cycle after the 3rd accept.
- start with x_in=2, coefs [1,0,0,1,1] (x^4+x+1 at alpha) -> res_data=0, res_count=5, res_zero=1 when the macro is defined.
- start with x_in=3, coefs [1,1], res_ready held 0 for 5 cycles -> res_data=2 held stable with res_valid=1 throughout; returns to IDLE the cycle after res_ready=1; coef_ready=0 during DONE.
- coef_valid toggling 1,0,0,1 with x_in=1, coefs [7,9] -> res_data=0xE; extra start pulses during ACCUM ignored; busy=1 from start+1 until the handshake.
- rst asserted after 2 of 4 coefficients -> next cycle busy=0, coef_ready=0, res_valid=0; a new evaluation with x_in=0, coefs [4,6] -> res_data=6.
- coef_valid=1 in IDLE with no start -> no accept, no state change; a single coefficient 0xB with coef_last -> res_data=0xB, res_count=1.
